// File: rtl/linear_pkg.sv
//============================================================================
// Module      : linear_pkg
// Description : Shared constants and FSM state type for the linear-unit
//               result collector.
//               LIN_DW    - data word width (fp32 bit pattern, opaque)
//               LIN_DEPTH - result buffer entries (3 segments x 32)
//               LIN_SEG   - entries per output segment
//               state_t   - collector FSM states
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package linear_pkg;

    localparam int LIN_DW    = 32;
    localparam int LIN_DEPTH = 96;
    localparam int LIN_SEG   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage : linear_pkg

`default_nettype wire

// File: rtl/linear_result_collector_2ports.sv
//============================================================================
// Module      : linear_result_collector_2ports
// Description : Collects result pairs from two linear units into a flop
//               buffer. Each res_valid pulse writes res1 to mem[wptr] and
//               res2 to mem[wptr+1]. One output segment of SEG entries is
//               read combinationally through vec_out.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               start      - pulse arming a collection (IDLE only)
//               addr_base  - first buffer index written, sampled on start
//               num_pairs  - pairs expected, sampled on start
//               res_valid  - pulse marking res1/res2 valid
//               res1/res2  - even/odd index results
//               rd_seg     - output segment select (3 reads as zeros)
//               busy       - high while collecting
//               complete   - one-cycle pulse after the last pair
//               vec_ready  - level from complete until the next start
//               overflow   - sticky, a write hit an index >= DEPTH
//               vec_out    - entries rd_seg*SEG .. rd_seg*SEG+SEG-1
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module linear_result_collector_2ports
    import linear_pkg::*;
#(
    parameter int DW    = LIN_DW,
    parameter int DEPTH = LIN_DEPTH,
    parameter int SEG   = LIN_SEG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [6:0]    addr_base,
    input  logic [5:0]    num_pairs,
    input  logic          res_valid,
    input  logic [DW-1:0] res1,
    input  logic [DW-1:0] res2,
    input  logic [1:0]    rd_seg,
    output logic          busy,
    output logic          complete,
    output logic          vec_ready,
    output logic          overflow,
    output logic [DW-1:0] vec_out [SEG-1:0]
);

    localparam int c_IDX_W = $clog2(DEPTH);

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_wptr;
    logic [5:0]    r_remaining;
    logic          r_vec_ready;
    logic          r_overflow;
    logic [DW-1:0] r_mem [DEPTH];

    logic [7:0]    w_wptr_odd;
    logic          w_even_ok;
    logic          w_odd_ok;
    logic          w_pair_wr;
    logic [31:0]   w_rd_idx;

    // wptr is 8 bits and can run past DEPTH; out-of-range halves are dropped
    // individually so an in-range partner still lands in the buffer.
    assign w_wptr_odd = r_wptr + 8'd1;
    assign w_even_ok  = (32'(r_wptr)     < 32'(DEPTH));
    assign w_odd_ok   = (32'(w_wptr_odd) < 32'(DEPTH));
    assign w_pair_wr  = (r_state == COLLECT) && res_valid;

    //------------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //------------------------------------------------------------------------
    // FSM: next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (num_pairs == 6'd0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (res_valid && (r_remaining == 6'd1)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    //------------------------------------------------------------------------
    always_comb begin
        busy     = (r_state == COLLECT);
        complete = (r_state == DONE);
    end

    assign vec_ready = r_vec_ready;
    assign overflow  = r_overflow;

    //------------------------------------------------------------------------
    // Datapath: pointer, pair counter, status flags, buffer
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= 8'd0;
            r_remaining <= 6'd0;
            r_vec_ready <= 1'b0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    // A res_valid coinciding with start is deliberately dropped.
                    if (start) begin
                        r_wptr      <= {1'b0, addr_base};
                        r_remaining <= num_pairs;
                        r_vec_ready <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (w_pair_wr) begin
                        if (w_even_ok) begin
                            r_mem[r_wptr[c_IDX_W-1:0]] <= res1;
                        end
                        if (w_odd_ok) begin
                            r_mem[w_wptr_odd[c_IDX_W-1:0]] <= res2;
                        end
                        if (!w_even_ok || !w_odd_ok) begin
                            r_overflow <= 1'b1;
                        end
                        r_wptr      <= r_wptr + 8'd2;
                        r_remaining <= r_remaining - 6'd1;
                    end
                end
                DONE: begin
                    r_vec_ready <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Segment read: full segment every cycle; indices past DEPTH read zero
    //------------------------------------------------------------------------
    always_comb begin
        w_rd_idx = '0;
        for (int i = 0; i < SEG; i++) begin
            w_rd_idx   = 32'(rd_seg) * 32'(SEG) + 32'(i);
            vec_out[i] = (w_rd_idx < 32'(DEPTH)) ? r_mem[w_rd_idx[c_IDX_W-1:0]] : '0;
        end
    end

endmodule : linear_result_collector_2ports

`default_nettype wire

// File: tb/tb_linear_result_collector_2ports.sv
//============================================================================
// Module      : tb_linear_result_collector_2ports
// Description : Randomized self-checking bench for the result collector.
//               A reference buffer array and overflow flag are updated from
//               the pair-writing rules and compared with every segment.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_linear_result_collector_2ports;

    localparam int DW    = 32;
    localparam int DEPTH = 96;
    localparam int SEG   = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [6:0]    addr_base;
    logic [5:0]    num_pairs;
    logic          res_valid;
    logic [DW-1:0] res1;
    logic [DW-1:0] res2;
    logic [1:0]    rd_seg;
    logic          busy;
    logic          complete;
    logic          vec_ready;
    logic          overflow;
    logic [DW-1:0] vec_out [SEG-1:0];

    linear_result_collector_2ports #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .SEG   (SEG)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .addr_base (addr_base),
        .num_pairs (num_pairs),
        .res_valid (res_valid),
        .res1      (res1),
        .res2      (res2),
        .rd_seg    (rd_seg),
        .busy      (busy),
        .complete  (complete),
        .vec_ready (vec_ready),
        .overflow  (overflow),
        .vec_out   (vec_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_ovf;
    logic [DW-1:0] last_r2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all four segment selects against the reference buffer.
    task automatic check_mem();
        logic [31:0] exp;
        for (int s = 0; s < 4; s++) begin
            rd_seg = 2'(s);
            #1;
            for (int i = 0; i < SEG; i++) begin
                exp = (s < 3) ? ref_mem[s*SEG + i] : 32'd0;
                check($sformatf("vec_out seg%0d[%0d]", s, i), vec_out[i], exp);
            end
        end
        rd_seg = 2'd0;
    endtask

    // One full collection, with stray traffic that must be ignored.
    task automatic run_txn(input int base, input int n, input int gap, input bit counting);
        int            g;
        int            idx;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;

        // res_valid while idle must not touch the buffer
        res_valid = 1'b1; res1 = $urandom; res2 = $urandom;
        tick();
        // start with a coincident res_valid: start wins, data discarded
        start = 1'b1; addr_base = 7'(base); num_pairs = 6'(n);
        res1 = $urandom; res2 = $urandom;
        tick();
        start = 1'b0; res_valid = 1'b0;
        ref_ovf = 1'b0;
        check("complete_after_start", complete, 32'(n == 0));
        check("busy_after_start", busy, 32'(n != 0));
        check("vec_ready_cleared", vec_ready, 0);

        for (int k = 0; k < n; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int j = 0; j < g; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    start     = 1'b1;
                    addr_base = 7'($urandom_range(0, 127));
                    num_pairs = 6'($urandom_range(0, 48));
                end
                tick();
                start = 1'b0;
                check("busy_gap", busy, 1);
                check("complete_gap", complete, 0);
            end
            r1 = counting ? 32'(2*k)     : $urandom;
            r2 = counting ? 32'(2*k + 1) : $urandom;
            res_valid = 1'b1; res1 = r1; res2 = r2;
            tick();
            res_valid = 1'b0;
            idx = base + 2*k;
            if (idx < DEPTH)     ref_mem[idx]     = r1; else ref_ovf = 1'b1;
            if (idx + 1 < DEPTH) ref_mem[idx + 1] = r2; else ref_ovf = 1'b1;
            last_r2 = r2;
            check("complete_pair", complete, 32'(k == n - 1));
            check("busy_pair", busy, 32'(k != n - 1));
        end

        // start during the single DONE cycle is ignored
        start = 1'b1; addr_base = 7'($urandom_range(0, 127)); num_pairs = 6'd5;
        tick();
        start = 1'b0;
        check("complete_end", complete, 0);
        check("busy_end", busy, 0);
        check("vec_ready_end", vec_ready, 1);
        check("overflow_end", overflow, 32'(ref_ovf));
        check_mem();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; addr_base = '0; num_pairs = '0;
        res_valid = 1'b0; res1 = '0; res2 = '0; rd_seg = '0;
        ref_ovf = 1'b0; last_r2 = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_complete", complete, 0);
        check("reset_vec_ready", vec_ready, 0);
        check("reset_overflow", overflow, 0);
        check_mem();
        rst_n = 1'b1;
        tick();

        // counting pattern into segment 0
        run_txn(0, 16, 0, 1'b1);
        rd_seg = 2'd0;
        #1;
        for (int i = 0; i < SEG; i++) check("seg0_counting", vec_out[i], 32'(i));

        // segments 1..2, pulses three cycles apart
        run_txn(32, 32, 2, 1'b0);
        rd_seg = 2'd2;
        #1;
        check("seg2_last_res2", vec_out[31], last_r2);

        // zero pairs: immediate completion, buffer untouched
        run_txn(0, 0, 0, 1'b0);

        // straddling the end of the buffer
        run_txn(94, 2, 0, 1'b0);
        check("overflow_edge", overflow, 1);

        // randomized collections
        for (int t = 0; t < 8; t++) begin
            run_txn(int'($urandom_range(0, 127)), int'($urandom_range(0, 48)), -1, 1'b0);
        end

        // reset mid-collection aborts and clears everything
        start = 1'b1; addr_base = 7'd0; num_pairs = 6'd16;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            res_valid = 1'b1; res1 = $urandom; res2 = $urandom;
            tick();
        end
        res_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_complete", complete, 0);
        check("mid_reset_vec_ready", vec_ready, 0);
        check("mid_reset_overflow", overflow, 0);
        check_mem();
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("post_reset_complete", complete, 0);
            check("post_reset_busy", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_linear_result_collector_2ports

`default_nettype wire

// File: doc/linear_result_collector_2ports.md
LINEAR_RESULT_COLLECTOR_2PORTS -- requirements
Module: linear_result_collector_2ports

Interface
REQ-001 SHALL have parameter DW, default 32, data word width (fp32 bit pattern, never interpreted).
REQ-002 SHALL have parameter DEPTH, default 96, result buffer entries (3 segments x 32).
REQ-003 SHALL have parameter SEG, default 32, entries per output segment.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse arming a collection.
REQ-007 SHALL have port addr_base  input  7  first buffer index written, sampled on start.
REQ-008 SHALL have port num_pairs  input  6  result pairs expected (0..48), sampled on start.
REQ-009 SHALL have port res_valid  input  1  one-cycle pulse marking res1/res2 valid (driven by linear-unit done).
REQ-010 SHALL have port res1  input  DW  even-index result (unit 1).
REQ-011 SHALL have port res2  input  DW  odd-index result (unit 2).
REQ-012 SHALL have port rd_seg  input  2  output segment select, 0..2.
REQ-013 SHALL have port busy  output  1  high while collecting.
REQ-014 SHALL have port complete  output  1  one-cycle pulse when the last expected pair is written.
REQ-015 SHALL have port vec_ready  output  1  level high from complete until next start.
REQ-016 SHALL have port overflow  output  1  sticky error: write attempted at index >= DEPTH.
REQ-017 SHALL have port vec_out  output  DW x SEG (unpacked [SEG-1:0])  buffer entries rd_seg*SEG .. rd_seg*SEG+SEG-1.

Function
REQ-018 SHALL implement states IDLE, COLLECT, DONE.
REQ-019 IDLE + start: wptr<=addr_base, remaining<=num_pairs, vec_ready<=0, overflow<=0; next COLLECT, or DONE if num_pairs==0.
REQ-020 COLLECT + res_valid: mem[wptr]<=res1, mem[wptr+1]<=res2, wptr<=wptr+2, remaining<=remaining-1, same edge.
REQ-021 COLLECT, res_valid with remaining==1: next state DONE.
REQ-022 DONE lasts exactly one cycle: complete=1, vec_ready<=1; next IDLE.
REQ-023 busy SHALL equal (state==COLLECT), registered-state decode, no combinational input path.
REQ-024 Write latency: written data visible on vec_out the cycle after res_valid edge.
REQ-025 wptr SHALL be 8 bits; any write whose index >= DEPTH is dropped, sets overflow; the other half of the pair is still written if in range; pair still counted.
REQ-026 start while COLLECT or DONE SHALL be ignored.
REQ-027 res_valid in IDLE or DONE SHALL be ignored; buffer unchanged.
REQ-028 start and res_valid in same IDLE cycle: start taken, result discarded.
REQ-029 vec_out SHALL be combinational from mem and rd_seg; rd_seg==3 yields all zeros.
REQ-030 Buffer contents SHALL persist across start; only written indices change.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, wptr 0, remaining 0, all mem entries 0, busy 0, complete 0, vec_ready 0, overflow 0.
REQ-032 Reset mid-COLLECT SHALL abort; no complete pulse after release.

Structure
REQ-033 State enum, DW, DEPTH, SEG constants SHALL live in shared package linear_pkg.
REQ-034 Single module, no sub-modules; buffer as flop array (no BRAM, full-segment read each cycle).

Verification
REQ-035 start(addr_base=0,num_pairs=16), 16 res_valid pulses res1=2k,res2=2k+1 -> mem[0..31]=0..31, complete one cycle after 16th pulse, rd_seg=0 vec_out[i]=i.
REQ-036 start(addr_base=0x20,num_pairs=32), pulses spaced 3 cycles -> mem[32..95] filled, busy high throughout, rd_seg=2 vec_out[31]=last res2.
REQ-037 start(num_pairs=0) -> complete next cycle, busy never high, buffer unchanged.
REQ-038 start(addr_base=94,num_pairs=2) -> mem[94],mem[95] written, second pair dropped, overflow=1, complete still pulses.
REQ-039 rst_n low after 5 of 16 pulses -> all outputs and vec_out 0 immediately, no complete; stray res_valid in IDLE and start during COLLECT ignored.
